// File: rtl/contador_desc_mod_n.sv
// Programmable modulo-(N+1) down-counter/timer with terminal-count pulse,
// one-shot or auto-reload operation and a sticky done flag.
//
// state | meaning
// IDLE  | stopped, Q held at 0, waiting for start
// RUN   | counting latched N down to 0 on enabled cycles
// DONE  | one-shot finished, Q held at 0, done asserted until start/stop
module contador_desc_mod_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] N,
    input  logic             start,
    input  logic             en,
    input  logic             auto,
    input  logic             stop,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_lat, n_lat_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             auto_lat, auto_lat_nxt;
    logic             tc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            Q        <= '0;
            tc       <= 1'b0;
            n_lat    <= '0;
            auto_lat <= 1'b0;
        end else begin
            state    <= state_nxt;
            Q        <= q_nxt;
            tc       <= tc_nxt;
            n_lat    <= n_lat_nxt;
            auto_lat <= auto_lat_nxt;
        end
    end

    // Priority in every state: stop > start > en.
    always_comb begin
        state_nxt    = state;
        q_nxt        = Q;
        n_lat_nxt    = n_lat;
        auto_lat_nxt = auto_lat;
        tc_nxt       = 1'b0;
        case (state)
            IDLE: begin
                q_nxt = '0;
                if (!stop && start) begin
                    state_nxt    = RUN;
                    q_nxt        = N;
                    n_lat_nxt    = N;
                    auto_lat_nxt = auto;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    q_nxt     = '0;
                end else if (start) begin
                    q_nxt        = N;
                    n_lat_nxt    = N;
                    auto_lat_nxt = auto;
                end else if (en) begin
                    if (Q != '0) begin
                        q_nxt = Q - WIDTH'(1);
                    end else begin
                        // Zero never decrements: it either reloads or ends the shot.
                        tc_nxt = 1'b1;
                        if (auto_lat) begin
                            q_nxt = n_lat;
                        end else begin
                            state_nxt = DONE;
                            q_nxt     = '0;
                        end
                    end
                end
            end
            DONE: begin
                q_nxt = '0;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt    = RUN;
                    q_nxt        = N;
                    n_lat_nxt    = N;
                    auto_lat_nxt = auto;
                end
            end
            default: begin
                state_nxt = IDLE;
                q_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule
